arith_responder: RTL and testbench

ARITH_RESPONDER -- requirements
Module: arith_responder

---
 rtl/arith_pkg.sv | 18 +
 rtl/arith_rsp_fifo.sv | 57 +++++
 rtl/arith_responder.sv | 103 ++++++++++
 tb/tb_arith_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic responder: opcodes, default widths
// and the buffered response entry layout.
package arith_pkg;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    localparam int WORD_W = 24;
    localparam int TAG_W  = 4;

    // Entry layout at default widths; the top packs the same fields in this order.
    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              overflow;
    } rspEntry_t;

endpackage

// File: rtl/arith_rsp_fifo.sv
// Synchronous response buffer. The head output keeps showing the last popped
// entry while the buffer is empty, so downstream sees stable values.
module arith_rsp_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [WIDTH-1:0] lastOut;
    logic             doPush, doPop;

    assign full     = (count == DEPTH_V);
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = empty ? lastOut : mem[rdPtr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            lastOut <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop) begin
                rdPtr   <= rdPtr + 1'b1;
                lastOut <= mem[rdPtr];
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/arith_responder.sv
// Two-stage add/subtract responder with a credit-controlled response buffer;
// responses leave in acceptance order with tag and signed-overflow flag.
module arith_responder #(
    parameter int WORD_W     = arith_pkg::WORD_W,
    parameter int TAG_W      = arith_pkg::TAG_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqOp,
    input  logic [WORD_W-1:0] ReqA,
    input  logic [WORD_W-1:0] ReqB,
    input  logic [TAG_W-1:0]  ReqTag,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [WORD_W-1:0] RspData,
    output logic [TAG_W-1:0]  RspTag,
    output logic              RspOverflow,
    output logic              Busy,
    output logic [15:0]       OpCount
);
    import arith_pkg::*;

    localparam int ENTRY_W = WORD_W + TAG_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

    logic              accept, deliver;
    logic              s1Valid, s1Op;
    logic [WORD_W-1:0] s1A, s1B;
    logic [TAG_W-1:0]  s1Tag;
    logic              s2Valid, s2Ovf;
    logic [WORD_W-1:0] s2Data;
    logic [TAG_W-1:0]  s2Tag;
    logic [WORD_W-1:0] bOperand, sum;
    logic              ovf;
    logic [ENTRY_W-1:0] head;
    logic              fifoFull, fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;
    logic [CNT_W:0]    inFlight;

    // Credit counts every request that will eventually need a buffer slot.
    assign inFlight = {1'b0, fifoCount} + {{CNT_W{1'b0}}, s1Valid} + {{CNT_W{1'b0}}, s2Valid};
    assign ReqReady = (inFlight < DEPTH_V);
    assign accept   = ReqValid && ReqReady;
    assign RspValid = !fifoEmpty;
    assign deliver  = RspValid && RspReady;
    assign Busy     = s1Valid || s2Valid || !fifoEmpty;

    // Subtract as A + ~B + 1; with the inverted B the overflow test is the same for both ops.
    always_comb begin
        bOperand = (s1Op == OP_ADD) ? s1B : ~s1B;
        sum      = s1A + bOperand + {{(WORD_W-1){1'b0}}, (s1Op == OP_SUB)};
        ovf      = (s1A[WORD_W-1] == bOperand[WORD_W-1]) && (sum[WORD_W-1] != s1A[WORD_W-1]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
            OpCount <= '0;
        end else begin
            s1Valid <= accept;
            s2Valid <= s1Valid;
            if (deliver) OpCount <= OpCount + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            s1Op  <= ReqOp;
            s1A   <= ReqA;
            s1B   <= ReqB;
            s1Tag <= ReqTag;
        end
        if (s1Valid) begin
            s2Data <= sum;
            s2Tag  <= s1Tag;
            s2Ovf  <= ovf;
        end
    end

    arith_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) rspFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (s2Valid),
        .pushData ({s2Data, s2Tag, s2Ovf}),
        .pop      (deliver),
        .headData (head),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign {RspData, RspTag, RspOverflow} = head;

endmodule

// File: tb/tb_arith_responder.sv
// Directed bench for arith_responder: latency, overflow, backpressure,
// streaming order, mid-operation reset and delivery-counter wrap.
module tb_arith_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqOp = 1'b0;
    logic [23:0] ReqA = '0;
    logic [23:0] ReqB = '0;
    logic [3:0]  ReqTag = '0;
    logic        RspValid;
    logic        RspReady = 1'b0;
    logic [23:0] RspData;
    logic [3:0]  RspTag;
    logic        RspOverflow;
    logic        Busy;
    logic [15:0] OpCount;

    int nVec = 0;
    int nErr = 0;

    arith_responder dut (
        .clock       (clock),
        .reset       (reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqOp       (ReqOp),
        .ReqA        (ReqA),
        .ReqB        (ReqB),
        .ReqTag      (ReqTag),
        .RspValid    (RspValid),
        .RspReady    (RspReady),
        .RspData     (RspData),
        .RspTag      (RspTag),
        .RspOverflow (RspOverflow),
        .Busy        (Busy),
        .OpCount     (OpCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        ReqValid = 1'b0;
        RspReady = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic send(input logic op, input logic [23:0] a, input logic [23:0] b, input logic [3:0] tag);
        chk("send_ready", 32'(ReqReady), 32'd1);
        ReqValid = 1'b1;
        ReqOp = op;
        ReqA = a;
        ReqB = b;
        ReqTag = tag;
        step();
        ReqValid = 1'b0;
    endtask

    task automatic recv(input string name, input logic [23:0] d, input logic [3:0] tag, input logic ovf);
        int waitCyc = 0;
        while (!RspValid && waitCyc < 10) begin
            step();
            waitCyc++;
        end
        if (!RspValid) chk({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk({name, "_data"}, 32'(RspData), 32'(d));
            chk({name, "_tag"}, 32'(RspTag), 32'(tag));
            chk({name, "_ovf"}, 32'(RspOverflow), 32'(ovf));
        end
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
    endtask

    initial begin
        int acc;
        int sent;
        int got;
        int first;
        int last;
        int guard;

        // reset state
        doReset();
        chk("rst_rspvalid", 32'(RspValid), 32'd0);
        chk("rst_reqready", 32'(ReqReady), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_opcount", 32'(OpCount), 32'd0);
        chk("rst_data", 32'(RspData), 32'd0);
        chk("rst_tag", 32'(RspTag), 32'd0);
        chk("rst_ovf", 32'(RspOverflow), 32'd0);

        // single subtract with exact latency
        send(1'b0, 24'h000010, 24'h000003, 4'd5);
        chk("lat_n0_valid", 32'(RspValid), 32'd0);
        chk("lat_n0_busy", 32'(Busy), 32'd1);
        step();
        chk("lat_n1_valid", 32'(RspValid), 32'd0);
        step();
        chk("lat_n2_valid", 32'(RspValid), 32'd1);
        chk("sub_data", 32'(RspData), 32'h00000D);
        chk("sub_tag", 32'(RspTag), 32'd5);
        chk("sub_ovf", 32'(RspOverflow), 32'd0);
        step();
        chk("hold_valid", 32'(RspValid), 32'd1);
        chk("hold_data", 32'(RspData), 32'h00000D);
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
        chk("pop_valid", 32'(RspValid), 32'd0);
        chk("pop_busy", 32'(Busy), 32'd0);
        chk("pop_opcount", 32'(OpCount), 32'd1);
        chk("empty_hold_data", 32'(RspData), 32'h00000D);

        // overflow and wrap-around arithmetic
        send(1'b1, 24'h7FFFFF, 24'h000001, 4'd1);
        recv("add_ovf", 24'h800000, 4'd1, 1'b1);
        send(1'b0, 24'h800000, 24'h000001, 4'd2);
        recv("sub_ovf", 24'h7FFFFF, 4'd2, 1'b1);
        send(1'b1, 24'hFFFFFF, 24'h000001, 4'd3);
        recv("add_wrap", 24'h000000, 4'd3, 1'b0);
        send(1'b0, 24'h000000, 24'h000001, 4'd4);
        recv("sub_neg", 24'hFFFFFF, 4'd4, 1'b0);
        send(1'b0, 24'h7FFFFF, 24'hFFFFFF, 4'd6);
        recv("sub_negb_ovf", 24'h800000, 4'd6, 1'b1);

        // backpressure: only FIFO_DEPTH requests may be taken
        RspReady = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            ReqValid = 1'b1;
            ReqOp = 1'b1;
            ReqA = 24'(acc * 100);
            ReqB = 24'd1;
            ReqTag = 4'(acc);
            if (ReqReady) acc++;
            step();
        end
        ReqValid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_reqready", 32'(ReqReady), 32'd0);
        chk("bp_busy", 32'(Busy), 32'd1);
        RspReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(RspValid), 32'd1);
            chk("bp_tag", 32'(RspTag), 32'(i));
            chk("bp_data", 32'(RspData), 32'(i * 100 + 1));
            step();
        end
        RspReady = 1'b0;
        chk("bp_drained", 32'(RspValid), 32'd0);
        for (int i = 4; i < 8; i++) begin
            send(1'b1, 24'(i * 100), 24'd1, 4'(i));
            recv("bp_rest", 24'(i * 100 + 1), 4'(i), 1'b0);
        end

        // streaming, one per cycle
        doReset();
        RspReady = 1'b1;
        sent = 0; got = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (RspValid) begin
                chk("strm_tag", 32'(RspTag), 32'(got % 16));
                chk("strm_data", 32'(RspData), 32'(got * 4));
                if (got == 0) first = cyc;
                last = cyc;
                got++;
            end
            if (sent < 16) begin
                chk("strm_ready", 32'(ReqReady), 32'd1);
                ReqValid = 1'b1;
                ReqOp = 1'b1;
                ReqA = 24'(sent * 3);
                ReqB = 24'(sent);
                ReqTag = 4'(sent);
                sent++;
            end else ReqValid = 1'b0;
            step();
        end
        chk("strm_count", 32'(got), 32'd16);
        chk("strm_consecutive", 32'(last - first), 32'd15);
        chk("strm_opcount", 32'(OpCount), 32'd16);
        RspReady = 1'b0;

        // reset with requests in flight
        for (int i = 0; i < 3; i++) begin
            ReqValid = 1'b1;
            ReqOp = 1'b1;
            ReqA = 24'(i);
            ReqB = 24'd7;
            ReqTag = 4'(i + 9);
            step();
        end
        ReqValid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_valid", 32'(RspValid), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_opcount", 32'(OpCount), 32'd0);
        chk("mid_rst_ready", 32'(ReqReady), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_rst_stale", 32'(RspValid), 32'd0);
        end

        // OpCount wrap after 65535 deliveries
        doReset();
        RspReady = 1'b1;
        ReqValid = 1'b1;
        ReqOp = 1'b1;
        ReqA = '0;
        ReqB = '0;
        ReqTag = '0;
        acc = 0;
        guard = 0;
        while (acc < 65535 && guard < 70000) begin
            if (ReqReady) acc++;
            step();
            guard++;
        end
        ReqValid = 1'b0;
        chk("wrap_accepts", 32'(acc), 32'd65535);
        repeat (6) step();
        chk("wrap_pre", 32'(OpCount), 32'h0000FFFF);
        RspReady = 1'b0;
        send(1'b1, 24'd2, 24'd3, 4'd7);
        recv("wrap_last", 24'd5, 4'd7, 1'b0);
        chk("wrap_post", 32'(OpCount), 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
